// File: rtl/can_tx_scheduler_pkg.sv
// Shared types for the CAN transmit scheduler: mailbox layout, FSM states and
// the arbitration key used to order pending mailboxes.
package can_tx_scheduler_pkg;

    localparam int unsigned KEY_W = 32;

    typedef struct packed {
        logic [10:0]     id_std;
        logic [17:0]     id_ext;
        logic            ide;
        logic            rtr;
        logic [3:0]      dlc;
        logic [0:7][7:0] data;
        logic [14:0]     crc;
    } can_mbox_t;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LAUNCH,
        BUSY,
        COMPLETE,
        FAIL
    } sched_state_t;

    // Bit order follows the on-wire arbitration field: SRR/RTR, IDE, ext ID, RTR.
    function automatic logic [KEY_W-1:0] can_arb_key(input can_mbox_t m);
        return {m.id_std,
                m.ide ? 1'b1 : m.rtr,
                m.ide,
                m.ide ? m.id_ext : 18'h0,
                m.ide ? m.rtr : 1'b0};
    endfunction

endpackage

// File: rtl/can_tx_scheduler_prio_sel.sv
// Combinational minimum-key finder over the pending mailboxes; ties resolve to
// the lowest index.
module can_tx_prio_sel
    import can_tx_scheduler_pkg::*;
#(
    parameter  int unsigned N_MBOX = 4,
    localparam int unsigned IDX_W  = $clog2(N_MBOX)
) (
    input  logic [N_MBOX-1:0] i_req,
    input  logic [KEY_W-1:0]  i_key [N_MBOX],
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_valid
);

    logic [KEY_W-1:0] w_best_key;

    always_comb begin
        o_idx      = '0;
        o_valid    = 1'b0;
        w_best_key = '0;
        for (int unsigned i = 0; i < N_MBOX; i++) begin
            if (i_req[i] && (!o_valid || i_key[i] < w_best_key)) begin
                o_valid    = 1'b1;
                o_idx      = IDX_W'(i);
                w_best_key = i_key[i];
            end
        end
    end

endmodule

// File: rtl/can_tx_scheduler.sv
// Transmit mailbox scheduler: selects the lowest-key pending mailbox, hands it to
// the CAN transmitter and handles retry, abort and bus-off.
module can_tx_scheduler
    import can_tx_scheduler_pkg::*;
#(
    parameter  int unsigned N_MBOX    = 4,
    parameter  int unsigned MAX_RETRY = 0,
    localparam int unsigned IDX_W     = $clog2(N_MBOX)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_point,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [10:0]       wr_id_std,
    input  logic [17:0]       wr_id_ext,
    input  logic              wr_ide,
    input  logic              wr_rtr,
    input  logic [3:0]        wr_dlc,
    input  logic [63:0]       wr_data,
    input  logic [14:0]       wr_crc,
    input  logic [N_MBOX-1:0] abort_req,
    input  logic              tx_done,
    input  logic              arb_lost,
    input  logic              bus_off,
    output logic              start_tx,
    output logic [10:0]       tx_id_std,
    output logic [17:0]       tx_id_ext,
    output logic              tx_ide,
    output logic              tx_rtr1,
    output logic              tx_rtr2,
    output logic              tx_remote_req,
    output logic [3:0]        tx_dlc,
    output logic [14:0]       tx_crc,
    output logic [7:0]        tx_data [0:7],
    output logic [N_MBOX-1:0] pending,
    output logic [N_MBOX-1:0] tx_ok,
    output logic [N_MBOX-1:0] tx_fail,
    output logic              wr_reject,
    output logic              busy,
    output logic [IDX_W-1:0]  active_idx
);

    localparam logic [15:0] RETRY_LIM = 16'(MAX_RETRY);

    sched_state_t      r_state, w_state_nxt;
    can_mbox_t         r_mbox [N_MBOX];
    logic [N_MBOX-1:0] r_pending, r_tx_ok, r_tx_fail;
    logic              r_wr_reject, r_abort_pend;
    logic [IDX_W-1:0]  r_active_idx;
    logic [15:0]       r_retry_cnt;
    logic [10:0]       r_id_std;
    logic [17:0]       r_id_ext;
    logic              r_ide, r_rtr1, r_rtr2, r_remote_req;
    logic [3:0]        r_dlc;
    logic [14:0]       r_crc;
    logic [7:0]        r_data [0:7];

    logic [KEY_W-1:0]  w_keys [N_MBOX];
    logic [N_MBOX-1:0] w_active_mask, w_wr_set, w_abort_eff, w_sel_req, w_fin_mask;
    logic [IDX_W-1:0]  w_sel_idx;
    logic              w_sel_valid, w_in_flight, w_wr_reject, w_wr_accept, w_abort_act;
    logic              w_sp_done, w_sp_lost, w_retry_hit;
    logic [15:0]       w_retry_inc;
    can_mbox_t         w_wr_frame, w_win;

    assign w_in_flight   = r_state inside {LAUNCH, BUSY, COMPLETE, FAIL};
    assign w_active_mask = w_in_flight ? (N_MBOX'(1) << r_active_idx) : '0;
    assign w_wr_reject   = wr_en && (r_state inside {LAUNCH, BUSY}) && (wr_idx == r_active_idx);
    assign w_wr_accept   = wr_en && !w_wr_reject;
    assign w_wr_set      = w_wr_accept ? (N_MBOX'(1) << wr_idx) : '0;
    // A write in the same clock shields its mailbox from the abort.
    assign w_abort_eff   = abort_req & ~w_active_mask & ~w_wr_set;
    assign w_abort_act   = |(abort_req & w_active_mask);
    assign w_sel_req     = r_pending & ~w_abort_eff;
    assign w_sp_done     = tx_done && sample_point;
    assign w_sp_lost     = arb_lost && sample_point;
    assign w_retry_inc   = r_retry_cnt + 16'd1;
    assign w_retry_hit   = (MAX_RETRY != 0) && (w_retry_inc == RETRY_LIM);
    assign w_fin_mask    = (!bus_off && (r_state inside {COMPLETE, FAIL}))
                           ? (N_MBOX'(1) << r_active_idx) : '0;
    assign w_win         = r_mbox[w_sel_idx];
    assign w_wr_frame    = '{id_std: wr_id_std, id_ext: wr_id_ext, ide: wr_ide, rtr: wr_rtr,
                             dlc: wr_dlc, data: wr_data, crc: wr_crc};

    always_comb begin
        for (int unsigned i = 0; i < N_MBOX; i++) begin
            w_keys[i] = can_arb_key(r_mbox[i]);
        end
    end

    can_tx_prio_sel #(.N_MBOX(N_MBOX)) u_prio_sel (
        .i_req   (w_sel_req),
        .i_key   (w_keys),
        .o_idx   (w_sel_idx),
        .o_valid (w_sel_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus_off) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE:     if (|r_pending) w_state_nxt = SELECT;
                SELECT:   w_state_nxt = w_sel_valid ? LAUNCH : IDLE;
                LAUNCH:   if (sample_point) w_state_nxt = BUSY;
                BUSY: begin
                    if (w_sp_done)
                        w_state_nxt = COMPLETE;
                    else if (w_sp_lost)
                        w_state_nxt = (r_abort_pend || w_abort_act || w_retry_hit) ? FAIL : SELECT;
                end
                COMPLETE: w_state_nxt = IDLE;
                FAIL:     w_state_nxt = IDLE;
                default:  w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_MBOX; i++) r_mbox[i] <= '0;
            for (int unsigned b = 0; b < 8; b++)      r_data[b] <= '0;
            r_pending    <= '0;
            r_tx_ok      <= '0;
            r_tx_fail    <= '0;
            r_wr_reject  <= 1'b0;
            r_abort_pend <= 1'b0;
            r_active_idx <= '0;
            r_retry_cnt  <= '0;
            r_id_std     <= '0;
            r_id_ext     <= '0;
            r_ide        <= 1'b0;
            r_rtr1       <= 1'b0;
            r_rtr2       <= 1'b0;
            r_remote_req <= 1'b0;
            r_dlc        <= '0;
            r_crc        <= '0;
        end else begin
            if (w_wr_accept) r_mbox[wr_idx] <= w_wr_frame;
            r_pending   <= (r_pending & ~w_fin_mask & ~w_abort_eff) | w_wr_set;
            r_tx_ok     <= (r_state == COMPLETE) ? w_fin_mask : '0;
            r_tx_fail   <= ((r_state == FAIL) ? w_fin_mask : '0) | (w_abort_eff & r_pending);
            r_wr_reject <= w_wr_reject;

            if (w_state_nxt inside {IDLE, SELECT}) r_abort_pend <= 1'b0;
            else if (w_abort_act)                  r_abort_pend <= 1'b1;

            if (!bus_off && r_state inside {COMPLETE, FAIL})
                r_retry_cnt <= '0;
            else if (!bus_off && r_state == BUSY && w_sp_lost && !w_sp_done)
                r_retry_cnt <= w_retry_inc;

            if (!bus_off && r_state == SELECT && w_sel_valid) begin
                r_active_idx <= w_sel_idx;
                r_id_std     <= w_win.id_std;
                r_id_ext     <= w_win.id_ext;
                r_ide        <= w_win.ide;
                r_rtr1       <= w_win.ide | w_win.rtr;
                r_rtr2       <= w_win.ide & w_win.rtr;
                r_remote_req <= w_win.rtr;
                r_dlc        <= (w_win.dlc > 4'd8) ? 4'd8 : w_win.dlc;
                r_crc        <= w_win.crc;
                for (int unsigned b = 0; b < 8; b++) r_data[b] <= w_win.data[b];
            end
        end
    end

    assign start_tx      = (r_state == LAUNCH) && !bus_off;
    assign busy          = (r_state != IDLE);
    assign pending       = r_pending;
    assign tx_ok         = r_tx_ok;
    assign tx_fail       = r_tx_fail;
    assign wr_reject     = r_wr_reject;
    assign active_idx    = r_active_idx;
    assign tx_id_std     = r_id_std;
    assign tx_id_ext     = r_id_ext;
    assign tx_ide        = r_ide;
    assign tx_rtr1       = r_rtr1;
    assign tx_rtr2       = r_rtr2;
    assign tx_remote_req = r_remote_req;
    assign tx_dlc        = r_dlc;
    assign tx_crc        = r_crc;
    assign tx_data       = r_data;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Self-checking bench for can_tx_scheduler: directed scenarios plus randomized
// mailbox loads checked against a priority-ordering reference model.
module tb_can_tx_scheduler;
    import can_tx_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_point = 1'b0, wr_en = 1'b0;
    logic [1:0]  wr_idx = '0;
    logic [10:0] wr_id_std = '0;
    logic [17:0] wr_id_ext = '0;
    logic        wr_ide = 1'b0, wr_rtr = 1'b0;
    logic [3:0]  wr_dlc = '0;
    logic [63:0] wr_data = '0;
    logic [14:0] wr_crc = '0;
    logic [3:0]  abort_req = '0;
    logic        tx_done = 1'b0, arb_lost = 1'b0, bus_off = 1'b0;
    logic        start_tx, tx_ide, tx_rtr1, tx_rtr2, tx_remote_req, wr_reject, busy;
    logic [10:0] tx_id_std;
    logic [17:0] tx_id_ext;
    logic [3:0]  tx_dlc;
    logic [14:0] tx_crc;
    logic [7:0]  tx_data [0:7];
    logic [3:0]  pending, tx_ok, tx_fail;
    logic [1:0]  active_idx;

    can_tx_scheduler #(.N_MBOX(4), .MAX_RETRY(2)) dut (
        .clk(clk), .rst_n(rst_n), .sample_point(sample_point),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_id_std(wr_id_std), .wr_id_ext(wr_id_ext),
        .wr_ide(wr_ide), .wr_rtr(wr_rtr), .wr_dlc(wr_dlc), .wr_data(wr_data), .wr_crc(wr_crc),
        .abort_req(abort_req), .tx_done(tx_done), .arb_lost(arb_lost), .bus_off(bus_off),
        .start_tx(start_tx), .tx_id_std(tx_id_std), .tx_id_ext(tx_id_ext), .tx_ide(tx_ide),
        .tx_rtr1(tx_rtr1), .tx_rtr2(tx_rtr2), .tx_remote_req(tx_remote_req), .tx_dlc(tx_dlc),
        .tx_crc(tx_crc), .tx_data(tx_data), .pending(pending), .tx_ok(tx_ok), .tx_fail(tx_fail),
        .wr_reject(wr_reject), .busy(busy), .active_idx(active_idx)
    );

    always #5 clk = ~clk;

    int        n_checks = 0;
    int        n_fail   = 0;
    can_mbox_t mdl_mb [4];
    logic [3:0] mdl_pend = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Key as an integer: id_std dominates, then std-data < std-remote < any extended.
    function automatic longint ref_key(input can_mbox_t m);
        if (m.ide)
            return longint'(m.id_std) * 2097152 + 1048576 + 524288 + longint'(m.id_ext) * 2 + longint'(m.rtr);
        return longint'(m.id_std) * 2097152 + longint'(m.rtr) * 1048576;
    endfunction

    function automatic int ref_winner();
        int     w = -1;
        longint best = 0;
        for (int i = 0; i < 4; i++) begin
            if (mdl_pend[i] && (w < 0 || ref_key(mdl_mb[i]) < best)) begin
                w = i;
                best = ref_key(mdl_mb[i]);
            end
        end
        return w;
    endfunction

    function automatic can_mbox_t rand_mb();
        can_mbox_t m;
        m.id_std = 11'($urandom_range(0, 2047));
        m.id_ext = 18'($urandom_range(0, 262143));
        m.ide    = 1'($urandom_range(0, 1));
        m.rtr    = 1'($urandom_range(0, 1));
        m.dlc    = 4'($urandom_range(0, 15));
        m.data   = {$urandom, $urandom};
        m.crc    = 15'($urandom_range(0, 32767));
        return m;
    endfunction

    task automatic write_mb(input int idx, input can_mbox_t m);
        wr_idx    = 2'(idx);
        wr_id_std = m.id_std;
        wr_id_ext = m.id_ext;
        wr_ide    = m.ide;
        wr_rtr    = m.rtr;
        wr_dlc    = m.dlc;
        wr_data   = m.data;
        wr_crc    = m.crc;
        wr_en     = 1'b1;
        tick();
        wr_en     = 1'b0;
    endtask

    task automatic load_mb(input int idx, input can_mbox_t m);
        write_mb(idx, m);
        mdl_mb[idx]   = m;
        mdl_pend[idx] = 1'b1;
    endtask

    task automatic wait_start(input string tag);
        int k = 0;
        while (!start_tx && k < 30) begin
            tick();
            k++;
        end
        chk({tag, ".start"}, start_tx, 1);
    endtask

    task automatic launch(input string tag);
        wait_start(tag);
        tick();
        chk({tag, ".hold"}, start_tx, 1);
        sample_point = 1'b1;
        tick();
        sample_point = 1'b0;
        chk({tag, ".drop"}, {busy, start_tx}, 2'b10);
    endtask

    task automatic check_frame(input string tag, input int idx);
        can_mbox_t   m = mdl_mb[idx];
        logic [63:0] d = '0;
        for (int b = 0; b < 8; b++) d = (d << 8) | 64'(tx_data[b]);
        chk({tag, ".idx"}, active_idx, idx);
        chk({tag, ".id"}, {tx_id_std, tx_ide, m.ide ? tx_id_ext : 18'h0},
            {m.id_std, m.ide, m.ide ? m.id_ext : 18'h0});
        chk({tag, ".rtr"}, {tx_rtr1, tx_rtr2, tx_remote_req},
            {m.ide ? 1'b1 : m.rtr, m.ide ? m.rtr : 1'b0, m.rtr});
        chk({tag, ".dlc"}, tx_dlc, (m.dlc > 8) ? 8 : m.dlc);
        chk({tag, ".crc"}, tx_crc, m.crc);
        chk({tag, ".data"}, d, m.data);
    endtask

    task automatic wait_pulse(output logic [3:0] ok, output logic [3:0] fl);
        ok = '0;
        fl = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            ok |= tx_ok;
            fl |= tx_fail;
            if (tx_ok != 0 || tx_fail != 0) break;
        end
    endtask

    task automatic finish_ok(input string tag, input int idx);
        logic [3:0] ok, fl;
        tx_done = 1'b1;
        sample_point = 1'b1;
        tick();
        tx_done = 1'b0;
        sample_point = 1'b0;
        wait_pulse(ok, fl);
        mdl_pend[idx] = 1'b0;
        chk({tag, ".ok"}, {ok, fl}, {4'(1 << idx), 4'h0});
        chk({tag, ".pend"}, pending, mdl_pend);
    endtask

    task automatic serve_all(input string tag);
        int w;
        while (mdl_pend != 0) begin
            w = ref_winner();
            launch(tag);
            check_frame(tag, w);
            finish_ok(tag, w);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        can_mbox_t  m, m2;
        logic [3:0] ok, fl;
        logic [63:0] d;

        // Reset state
        tick();
        d = '0;
        for (int b = 0; b < 8; b++) d = (d << 8) | 64'(tx_data[b]);
        chk("rst.ctl", {start_tx, busy, wr_reject, pending, tx_ok, tx_fail, active_idx}, '0);
        chk("rst.frame", {tx_id_std, tx_id_ext, tx_ide, tx_rtr1, tx_rtr2, tx_remote_req, tx_dlc, tx_crc}, '0);
        chk("rst.data", d, '0);
        rst_n = 1'b1;
        tick();

        // 1: single std frame through MB2
        m = '0;
        m.id_std = 11'h123;
        m.dlc = 4'd2;
        m.data = 64'hAA55_0000_0000_0000;
        m.crc = 15'h1A2B;
        load_mb(2, m);
        chk("t1.pend", pending, 4'b0100);
        launch("t1");
        check_frame("t1", 2);
        finish_ok("t1", 2);
        tick();
        chk("t1.pulse", tx_ok, 0);

        // 2: priority by ID, then std beats ext with equal base ID
        bus_off = 1'b1;
        m = rand_mb(); m.id_std = 11'h200; m.ide = 1'b0; load_mb(0, m);
        m = rand_mb(); m.id_std = 11'h100; m.ide = 1'b0; load_mb(1, m);
        bus_off = 1'b0;
        serve_all("t2a");
        bus_off = 1'b1;
        m = rand_mb(); m.id_std = 11'h100; m.ide = 1'b1; load_mb(0, m);
        m = rand_mb(); m.id_std = 11'h100; m.ide = 1'b0; m.rtr = 1'b1; load_mb(1, m);
        bus_off = 1'b0;
        serve_all("t2b");

        // 3: retry limit of 2
        load_mb(0, rand_mb());
        launch("t3a");
        check_frame("t3a", 0);
        arb_lost = 1'b1; sample_point = 1'b1;
        tick();
        arb_lost = 1'b0; sample_point = 1'b0;
        chk("t3.reselect", {busy, start_tx, tx_fail}, {1'b1, 1'b0, 4'h0});
        launch("t3b");
        check_frame("t3b", 0);
        arb_lost = 1'b1; sample_point = 1'b1;
        tick();
        arb_lost = 1'b0; sample_point = 1'b0;
        wait_pulse(ok, fl);
        mdl_pend[0] = 1'b0;
        chk("t3.fail", {ok, fl}, {4'h0, 4'b0001});
        chk("t3.pend", pending, mdl_pend);

        // 4a: abort idle-pending MB3; abort racing a write to MB2
        bus_off = 1'b1;
        load_mb(3, rand_mb());
        abort_req = 4'b1000;
        tick();
        abort_req = '0;
        mdl_pend[3] = 1'b0;
        chk("t4.abort", {tx_fail, pending}, {4'b1000, mdl_pend});
        tick();
        chk("t4.pulse", tx_fail, 0);
        load_mb(2, rand_mb());
        m = rand_mb();
        abort_req = 4'b0100;
        load_mb(2, m);
        abort_req = '0;
        chk("t4.wrwin", {tx_fail, pending}, {4'h0, mdl_pend});
        bus_off = 1'b0;
        serve_all("t4w");

        // 4b: abort in-flight MB0, then success
        load_mb(0, rand_mb());
        launch("t4b");
        abort_req = 4'b0001;
        tick();
        abort_req = '0;
        chk("t4b.noabort", {tx_fail, busy}, {4'h0, 1'b1});
        finish_ok("t4b", 0);

        // 5: rejected write to active MB1, bus-off and resume
        load_mb(1, rand_mb());
        launch("t5");
        m2 = rand_mb();
        m2.id_std = ~mdl_mb[1].id_std;
        write_mb(1, m2);
        chk("t5.rej", wr_reject, 1);
        tick();
        chk("t5.rejpulse", wr_reject, 0);
        check_frame("t5.keep", 1);
        bus_off = 1'b1;
        tick();
        chk("t5.busoff", {busy, start_tx, pending, tx_ok, tx_fail}, {2'b00, 4'b0010, 8'h00});
        tick();
        tick();
        bus_off = 1'b0;
        launch("t5r");
        check_frame("t5r", 1);
        finish_ok("t5r", 1);

        // 6: reset mid-frame
        load_mb(2, rand_mb());
        launch("t6");
        #2 rst_n = 1'b0;
        #1;
        d = '0;
        for (int b = 0; b < 8; b++) d = (d << 8) | 64'(tx_data[b]);
        chk("t6.ctl", {start_tx, busy, pending, tx_ok, tx_fail, active_idx}, '0);
        chk("t6.frame", {tx_id_std, tx_dlc, d}, '0);
        tick();
        rst_n = 1'b1;
        mdl_pend = '0;
        tick();
        tick();
        chk("t6.idle", {busy, pending}, '0);

        // Randomized loads: several mailboxes (with occasional key ties) then drain
        for (int r = 0; r < 12; r++) begin
            int n;
            bus_off = 1'b1;
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                int idx, src;
                idx = $urandom_range(0, 3);
                m = rand_mb();
                src = $urandom_range(0, 3);
                if ($urandom_range(0, 2) == 0 && mdl_pend[src]) begin
                    m.id_std = mdl_mb[src].id_std;
                    m.id_ext = mdl_mb[src].id_ext;
                    m.ide    = mdl_mb[src].ide;
                    m.rtr    = mdl_mb[src].rtr;
                end
                load_mb(idx, m);
            end
            chk("rnd.pend", pending, mdl_pend);
            bus_off = 1'b0;
            serve_all("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
